// File: rtl/mesh_term_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mesh_term_pkg
// Brief   : Shared types, packet field offsets and helpers for mesh_term_bridge
// Revision: 1.0 - initial release
// ============================================================================
package mesh_term_pkg;

    // Header fields are located from the packet MSB down.
    localparam int NJ_W          = 8;
    localparam int ADDR_W        = 8;
    localparam int DEST_FROM_TOP = 8;
    localparam int MODE_FROM_TOP = 16;
    localparam int HDR_W         = 17;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
    } mesh_addr_t;

    typedef struct packed {
        logic [NJ_W-1:0] next_jump;
        mesh_addr_t      dest;
        logic            mode;
    } pkt_hdr_t;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_POP  = 2'd1,
        RX_HOLD = 2'd2
    } rx_state_e;

    // Terminals walk the mesh perimeter: top edge, left edge, bottom edge, right edge.
    function automatic mesh_addr_t term_addr(input int t, input int rows, input int cols);
        mesh_addr_t a;
        if (t < cols) begin
            a.row = 4'd0;
            a.col = 4'(t + 1);
        end else if (t < cols + rows) begin
            a.row = 4'(t - cols + 1);
            a.col = 4'd0;
        end else if (t < 2*cols + rows) begin
            a.row = 4'(rows + 1);
            a.col = 4'(t - cols - rows + 1);
        end else begin
            a.row = 4'(t - 2*cols - rows + 1);
            a.col = 4'(cols + 1);
        end
        return a;
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mesh_term_fifo.sv
`default_nettype none
// ============================================================================
// Module  : mesh_term_fifo
// Brief   : Synchronous show-ahead FIFO with registered ready (not-full) flag
// Revision: 1.0 - initial release
// ============================================================================
module mesh_term_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_ready,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_valid
);
    localparam int              c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_full = (c_aw+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic [c_aw:0]    w_count_next;
    logic             r_ready;
    logic             w_wr;
    logic             w_rd;

    assign o_ready   = r_ready;
    assign o_valid   = (r_count != '0);
    assign w_wr      = i_wr_en & r_ready;
    assign w_rd      = i_rd_en & o_valid;
    // Empty head reads as zero so the outputs are clean out of reset.
    assign o_rd_data = o_valid ? r_mem[r_rd_ptr] : '0;

    always_comb begin
        w_count_next = r_count;
        case ({w_wr, w_rd})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_ready <= (w_count_next != c_full);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/mesh_term_bridge.sv
`default_nettype none
// ============================================================================
// Module  : mesh_term_bridge
// Brief   : Per-terminal TX/RX FIFO bridge to every perimeter terminal of the
//           ROWS x COLUMNS mesh, with destination check and misroute counting.
//           Define MESH_TERM_DROP_MISROUTE_EN to discard misrouted packets.
// Revision: 1.0 - initial release
// ============================================================================
module mesh_term_bridge
    import mesh_term_pkg::*;
#(
    parameter int          ROWS       = 4,
    parameter int          COLUMNS    = 4,
    parameter int          PAKG_SIZE  = 32,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [7:0]  BDCST      = 8'hFF,
    localparam int         NTERM      = 2*(ROWS+COLUMNS)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NTERM-1:0]           tx_valid_i,
    input  logic [NTERM*PAKG_SIZE-1:0] tx_data_i,
    output logic [NTERM-1:0]           tx_ready_o,
    output logic [NTERM-1:0]           pndng_i_in,
    output logic [NTERM*PAKG_SIZE-1:0] data_out_i_in,
    input  logic [NTERM-1:0]           popin,
    input  logic [NTERM-1:0]           pndng,
    input  logic [NTERM*PAKG_SIZE-1:0] data_out,
    output logic [NTERM-1:0]           pop,
    output logic [NTERM-1:0]           rx_valid_o,
    output logic [NTERM*PAKG_SIZE-1:0] rx_data_o,
    input  logic [NTERM-1:0]           rx_ready_i,
    output logic [NTERM-1:0]           misroute_o,
    output logic [15:0]                misroute_cnt_o
);
`ifdef MESH_TERM_DROP_MISROUTE_EN
    localparam bit c_drop = 1'b1;
`else
    localparam bit c_drop = 1'b0;
`endif

    logic [NTERM-1:0] w_mis;
    logic [15:0]      w_mis_sum;
    logic [15:0]      r_mis_cnt;

    for (genvar t = 0; t < NTERM; t++) begin : g_term
        localparam mesh_addr_t c_addr = term_addr(t, ROWS, COLUMNS);

        rx_state_e  r_state;
        logic       r_pop;
        logic       r_misroute;
        logic       w_rx_ready;
        logic       w_rx_wr;
        logic       w_match;
        mesh_addr_t w_dest;

        mesh_term_fifo #(.WIDTH(PAKG_SIZE), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
            .clk       (clk_i),
            .rst_n     (rst_i),
            .i_wr_en   (tx_valid_i[t]),
            .i_wr_data (tx_data_i[t*PAKG_SIZE +: PAKG_SIZE]),
            .o_ready   (tx_ready_o[t]),
            .i_rd_en   (popin[t]),
            .o_rd_data (data_out_i_in[t*PAKG_SIZE +: PAKG_SIZE]),
            .o_valid   (pndng_i_in[t])
        );

        assign w_dest  = mesh_addr_t'(data_out[t*PAKG_SIZE + PAKG_SIZE-1-DEST_FROM_TOP -: ADDR_W]);
        assign w_match = (w_dest == c_addr) || (w_dest == BDCST);
        // The mesh holds data_out stable during the POP cycle; capture then.
        assign w_mis[t] = (r_state == RX_POP) && !w_match;
        assign w_rx_wr  = (r_state == RX_POP) && (w_match || !c_drop);

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                r_state    <= RX_IDLE;
                r_pop      <= 1'b0;
                r_misroute <= 1'b0;
            end else begin
                case (r_state)
                    RX_IDLE: begin
                        if (pndng[t] && w_rx_ready) begin
                            r_state <= RX_POP;
                            r_pop   <= 1'b1;
                        end
                    end
                    RX_POP: begin
                        r_state <= RX_HOLD;
                        r_pop   <= 1'b0;
                    end
                    RX_HOLD: r_state <= RX_IDLE;
                    default: begin
                        r_state <= RX_IDLE;
                        r_pop   <= 1'b0;
                    end
                endcase
                if (w_mis[t]) r_misroute <= 1'b1;
            end
        end

        mesh_term_fifo #(.WIDTH(PAKG_SIZE), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
            .clk       (clk_i),
            .rst_n     (rst_i),
            .i_wr_en   (w_rx_wr),
            .i_wr_data (data_out[t*PAKG_SIZE +: PAKG_SIZE]),
            .o_ready   (w_rx_ready),
            .i_rd_en   (rx_ready_i[t]),
            .o_rd_data (rx_data_o[t*PAKG_SIZE +: PAKG_SIZE]),
            .o_valid   (rx_valid_o[t])
        );

        assign pop[t]        = r_pop;
        assign misroute_o[t] = r_misroute;
    end : g_term

    always_comb begin
        w_mis_sum = '0;
        for (int i = 0; i < NTERM; i++) begin
            w_mis_sum = w_mis_sum + 16'(w_mis[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mis_cnt <= '0;
        end else if (|w_mis) begin
            r_mis_cnt <= sat_add16(r_mis_cnt, w_mis_sum);
        end
    end

    assign misroute_cnt_o = r_mis_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mesh_term_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_mesh_term_bridge
// Brief   : Directed, table-driven self-checking bench for mesh_term_bridge
// Revision: 1.0 - initial release
// ============================================================================
module tb_mesh_term_bridge;
    import mesh_term_pkg::*;

    localparam int NT = 16;
    localparam int W  = 32;
`ifdef MESH_TERM_DROP_MISROUTE_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_i;
    logic [NT-1:0]   tx_valid_i, tx_ready_o, pndng_i_in, popin, pndng, pop;
    logic [NT-1:0]   rx_valid_o, rx_ready_i, misroute_o;
    logic [NT*W-1:0] tx_data_i, data_out_i_in, data_out, rx_data_o;
    logic [15:0]     misroute_cnt_o;

    mesh_term_bridge dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .tx_valid_i     (tx_valid_i),
        .tx_data_i      (tx_data_i),
        .tx_ready_o     (tx_ready_o),
        .pndng_i_in     (pndng_i_in),
        .data_out_i_in  (data_out_i_in),
        .popin          (popin),
        .pndng          (pndng),
        .data_out       (data_out),
        .pop            (pop),
        .rx_valid_o     (rx_valid_o),
        .rx_data_o      (rx_data_o),
        .rx_ready_i     (rx_ready_i),
        .misroute_o     (misroute_o),
        .misroute_cnt_o (misroute_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] r, input logic [3:0] c, input logic [14:0] pl);
        pkt_hdr_t h;
        h = '{next_jump: 8'h00, dest: '{row: r, col: c}, mode: 1'b0};
        return {h, pl};
    endfunction

    typedef struct {
        int          term;
        logic [31:0] pkt;
        bit          mis;
    } rx_vec_t;

    rx_vec_t     vecs [12];
    logic [15:0] exp_flags;
    logic [15:0] exp_cnt;
    int          t, k, npop, last;
    bit          adv, found;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0,  32'h0101_00AB, 1'b0};
        vecs[1]  = '{0,  32'h0122_0055, 1'b1};
        vecs[2]  = '{3,  32'h0004_1234, 1'b0};
        vecs[3]  = '{4,  32'hFF10_8001, 1'b0};
        vecs[4]  = '{7,  32'h0040_0007, 1'b0};
        vecs[5]  = '{8,  32'h0051_BEEF, 1'b0};
        vecs[6]  = '{11, 32'h0054_0011, 1'b0};
        vecs[7]  = '{12, 32'h0015_0C0C, 1'b0};
        vecs[8]  = '{15, 32'h0045_FFFF, 1'b0};
        vecs[9]  = '{15, 32'h0054_0000, 1'b1};
        vecs[10] = '{9,  32'h00FF_0009, 1'b0};
        vecs[11] = '{2,  32'h0002_0000, 1'b1};
        exp_flags = '0;
        exp_cnt   = '0;

        rst_i = 1'b0; tx_valid_i = '0; tx_data_i = '0; popin = '0;
        pndng = '0; data_out = '0; rx_ready_i = '0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_tx_ready", 32'(tx_ready_o), 32'h0);
        check("rst_pndng_i_in", 32'(pndng_i_in), 32'h0);
        check("rst_pop", 32'(pop), 32'h0);
        check("rst_rx_valid", 32'(rx_valid_o), 32'h0);
        check("rst_misroute_cnt", 32'(misroute_cnt_o), 32'h0);
        rst_i = 1'b1;
        check("rel_tx_ready_no_edge", 32'(tx_ready_o), 32'h0);
        @(negedge clk);
        check("rel_tx_ready_first_edge", 32'(tx_ready_o), 32'hFFFF);

        // ---------------- TX fill and drain on t=5 ----------------
        for (int i = 0; i < 16; i++) begin
            tx_valid_i[5] = 1'b1;
            tx_data_i[5*W +: W] = 32'hA500_0000 + 32'(i);
            if (i == 0) check("tx_pndng_before_push", 32'(pndng_i_in[5]), 32'h0);
            @(negedge clk);
            if (i == 0) check("tx_pndng_latency", 32'(pndng_i_in[5]), 32'h1);
        end
        tx_data_i[5*W +: W] = 32'hDEAD_BEEF;
        check("tx_ready_full", 32'(tx_ready_o[5]), 32'h0);
        @(negedge clk);
        tx_valid_i[5] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("tx_head_order", data_out_i_in[5*W +: W], 32'hA500_0000 + 32'(i));
            popin[5] = 1'b1;
            @(negedge clk);
        end
        popin[5] = 1'b0;
        check("tx_pndng_drained", 32'(pndng_i_in[5]), 32'h0);
        check("tx_ready_drained", 32'(tx_ready_o[5]), 32'h1);

        // ---------------- RX table ----------------
        for (int i = 0; i < 12; i++) begin
            t = vecs[i].term;
            pndng[t] = 1'b1;
            data_out[t*W +: W] = vecs[i].pkt;
            check("rx_pop_idle", 32'(pop[t]), 32'h0);
            @(negedge clk);
            check("rx_pop_pulse", 32'(pop[t]), 32'h1);
            @(negedge clk);
            pndng[t] = 1'b0;
            check("rx_pop_single", 32'(pop[t]), 32'h0);
            if (vecs[i].mis) begin
                exp_cnt++;
                exp_flags[t] = 1'b1;
            end
            check("rx_valid", 32'(rx_valid_o[t]), (vecs[i].mis && DROP) ? 32'h0 : 32'h1);
            if (!(vecs[i].mis && DROP)) check("rx_data", rx_data_o[t*W +: W], vecs[i].pkt);
            check("rx_misroute_flags", 32'(misroute_o), 32'(exp_flags));
            check("rx_misroute_cnt", 32'(misroute_cnt_o), 32'(exp_cnt));
            rx_ready_i[t] = 1'b1;
            @(negedge clk);
            rx_ready_i[t] = 1'b0;
            check("rx_drained", 32'(rx_valid_o[t]), 32'h0);
        end

        // ---------------- simultaneous misroutes on t=4,5,6 ----------------
        for (int i = 4; i < 7; i++) begin
            pndng[i] = 1'b1;
            data_out[i*W +: W] = mk(4'd3, 4'd3, 15'(i));
        end
        repeat (2) @(negedge clk);
        pndng[6:4] = '0;
        exp_cnt += 16'd3;
        exp_flags[6:4] = 3'b111;
        check("multi_misroute_cnt", 32'(misroute_cnt_o), 32'(exp_cnt));
        check("multi_misroute_flags", 32'(misroute_o), 32'(exp_flags));
        check("multi_rx_valid", 32'(rx_valid_o[6:4]), DROP ? 32'h0 : 32'h7);
        rx_ready_i[6:4] = 3'b111;
        @(negedge clk);
        rx_ready_i = '0;

        // ---------------- broadcast on all terminals ----------------
        for (int i = 0; i < NT; i++) begin
            pndng[i] = 1'b1;
            data_out[i*W +: W] = 32'h00FF_0000 + 32'(i);
        end
        @(negedge clk);
        check("bcast_pop_all", 32'(pop), 32'hFFFF);
        @(negedge clk);
        pndng = '0;
        check("bcast_rx_valid_all", 32'(rx_valid_o), 32'hFFFF);
        check("bcast_no_new_flags", 32'(misroute_o), 32'(exp_flags));
        check("bcast_cnt_unchanged", 32'(misroute_cnt_o), 32'(exp_cnt));
        for (int i = 0; i < NT; i++) begin
            check("bcast_rx_data", rx_data_o[i*W +: W], 32'h00FF_0000 + 32'(i));
        end
        rx_ready_i = '1;
        @(negedge clk);
        rx_ready_i = '0;
        check("bcast_drained", 32'(rx_valid_o), 32'h0);

        // ---------------- RX backpressure on t=3 ----------------
        k = 0; npop = 0; last = -1; adv = 1'b0;
        pndng[3] = 1'b1;
        data_out[3*W +: W] = mk(4'd0, 4'd4, 15'(0));
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (adv) begin
                k++;
                if (k >= 20) pndng[3] = 1'b0;
                else data_out[3*W +: W] = mk(4'd0, 4'd4, 15'(k));
            end
            adv = pop[3];
            if (pop[3]) begin
                if (npop > 0) check("bp_spacing", 32'(c - last), 32'd3);
                last = c;
                npop++;
            end
        end
        check("bp_pop_count", 32'(npop), 32'd16);
        check("bp_head", rx_data_o[3*W +: W], mk(4'd0, 4'd4, 15'(0)));
        rx_ready_i[3] = 1'b1;
        @(negedge clk);
        rx_ready_i[3] = 1'b0;
        check("bp_head_after_read", rx_data_o[3*W +: W], mk(4'd0, 4'd4, 15'(1)));
        found = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (!found) begin
                @(negedge clk);
                if (pop[3]) found = 1'b1;
            end
        end
        check("bp_resume_pop", 32'(found), 32'h1);
        @(negedge clk);
        pndng[3] = 1'b0;
        rx_ready_i[3] = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            check("bp_drain_order", rx_data_o[3*W +: W], mk(4'd0, 4'd4, 15'(j)));
            @(negedge clk);
        end
        rx_ready_i[3] = 1'b0;
        check("bp_drained", 32'(rx_valid_o[3]), 32'h0);

        // ---------------- reset mid-traffic ----------------
        for (int i = 0; i < 3; i++) begin
            tx_valid_i[0] = 1'b1;
            tx_data_i[0 +: W] = 32'hC000_0000 + 32'(i);
            @(negedge clk);
        end
        tx_valid_i[0] = 1'b0;
        pndng[1] = 1'b1;
        data_out[1*W +: W] = mk(4'd0, 4'd2, 15'h11);
        repeat (3) @(negedge clk);
        pndng[1] = 1'b0;
        check("pre_rst_pndng_i_in", 32'(pndng_i_in[0]), 32'h1);
        check("pre_rst_rx_valid", 32'(rx_valid_o[1]), 32'h1);
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_pndng_i_in", 32'(pndng_i_in), 32'h0);
        check("mid_rst_rx_valid", 32'(rx_valid_o), 32'h0);
        check("mid_rst_cnt", 32'(misroute_cnt_o), 32'h0);
        check("mid_rst_flags", 32'(misroute_o), 32'h0);
        check("mid_rst_tx_ready", 32'(tx_ready_o), 32'h0);
        rst_i = 1'b1;
        @(negedge clk);
        check("post_rst_tx_ready", 32'(tx_ready_o), 32'hFFFF);
        check("post_rst_pndng_i_in", 32'(pndng_i_in), 32'h0);
        check("post_rst_pop", 32'(pop), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
